// File: rtl/ofifo_drain_pkg.sv
// rtl/ofifo_drain_pkg.sv - shared types and constants for the ofifo drain sequencer
package ofifo_drain_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int CNT_W_DEF  = 11;
    localparam int PERF_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } drain_state_t;

endpackage

// File: rtl/ofifo_drain_ctrl.sv
// rtl/ofifo_drain_ctrl.sv - drains complete ofifo vectors into consecutive psum SRAM rows
//
// Ports:
//   clk, reset         single clock, synchronous active-high reset
//   start              begin a drain (accepted only when idle)
//   base_addr          first SRAM address, sampled with start
//   num_rows           vectors to drain, sampled with start
//   ofifo_valid        ofifo holds a complete vector
//   ofifo_full         any ofifo column full
//   ofifo_rd           read strobe, one vector per high cycle
//   sram_cen/sram_wen  active-low SRAM enables, both low on a write cycle
//   sram_addr          SRAM address (the write pointer)
//   busy               drain in progress (DRAIN, FLUSH, DONE)
//   done               one-cycle completion pulse
//   array_hold         ofifo_full passed through as MAC back-pressure
//   perf_stall_cnt     only with OFIFO_DRAIN_PERF_EN: saturating count of
//                      DRAIN cycles starved of ofifo data
module ofifo_drain_ctrl
    import ofifo_drain_pkg::*;
#(
    parameter int addr_w = ADDR_W_DEF,
    parameter int cnt_w  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [addr_w-1:0] base_addr,
    input  logic [cnt_w-1:0]  num_rows,
    input  logic              ofifo_valid,
    input  logic              ofifo_full,
    output logic              ofifo_rd,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [addr_w-1:0] sram_addr,
    output logic              busy,
    output logic              done,
    output logic              array_hold
`ifdef OFIFO_DRAIN_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cnt
`endif
);

    drain_state_t      state_q;
    drain_state_t      state_d;
    logic [addr_w-1:0] wr_ptr;
    logic [cnt_w-1:0]  rd_left;
    logic [cnt_w-1:0]  wr_left;
    logic              wr_pend;
    logic              rd_fire;
    logic              start_acc;

    always_comb begin
        state_d   = state_q;
        rd_fire   = 1'b0;
        start_acc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = (num_rows == '0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                rd_fire = ofifo_valid && (rd_left != '0);
                // The last read leaves exactly one write outstanding; FLUSH retires it.
                if ((rd_fire && rd_left == cnt_w'(1)) || rd_left == '0) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wr_ptr  <= '0;
            rd_left <= '0;
            wr_left <= '0;
            wr_pend <= 1'b0;
        end else begin
            state_q <= state_d;
            // A read this cycle means the vector is on the ofifo bus next cycle.
            wr_pend <= rd_fire;
            if (start_acc) begin
                wr_ptr  <= base_addr;
                rd_left <= num_rows;
                wr_left <= num_rows;
            end else begin
                if (rd_fire) begin
                    rd_left <= rd_left - cnt_w'(1);
                end
                if (wr_pend) begin
                    wr_ptr <= wr_ptr + addr_w'(1);
                    if (wr_left != '0) begin
                        wr_left <= wr_left - cnt_w'(1);
                    end
                end
            end
        end
    end

    assign ofifo_rd   = rd_fire;
    assign sram_cen   = ~wr_pend;
    assign sram_wen   = ~wr_pend;
    assign sram_addr  = wr_ptr;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign array_hold = ofifo_full;

`ifdef OFIFO_DRAIN_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt <= '0;
        end else if (start_acc) begin
            perf_stall_cnt <= '0;
        end else if (state_q == ST_DRAIN && rd_left != '0 && !ofifo_valid
                     && perf_stall_cnt != {PERF_W{1'b1}}) begin
            perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
        end
    end
`endif

endmodule
